// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram
// Purpose  : Simple dual-port RAM, one write port and one registered read
//            port on a single clock. The read register only updates when
//            i_rd_en is high, so it can double as a holding register.
// Ports    : clk        - clock, rising edge
//            i_wr_en    - write strobe
//            i_wr_addr  - write word address
//            i_wr_data  - write word
//            i_rd_en    - read strobe (loads o_rd_data on the next edge)
//            i_rd_addr  - read word address
//            o_rd_data  - registered read word
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage has no reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      rd_data_q <= mem[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/data_storage_acc.sv
`default_nettype none
// ============================================================================
// Module   : data_storage_acc
// Purpose  : Fast-ADC capture buffer. A FastTrigger pulse in IDLE records
//            DEPTH consecutive 32-bit words; the record is then streamed out
//            one byte at a time (low byte of each word first, words in
//            ascending order) under a ready/strobe handshake.
// Ports    : Clock       - system clock, rising edge
//            Reset       - asynchronous active-low reset
//            DataIn      - four 8-bit ADC samples, [7:0] oldest
//            FastTrigger - capture start request (honoured in IDLE only)
//            ReadEnable  - strobe consuming the byte on DataOut
//            DataOut     - current readout byte (valid while DataReady)
//            DataReady   - high while unread bytes remain
// Revision : 1.0 - initial release
// ============================================================================
module data_storage_acc #(
  parameter int DEPTH = 256   // power of two, >= 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] DataIn,
  input  logic        FastTrigger,
  input  logic        ReadEnable,
  output logic [7:0]  DataOut,
  output logic        DataReady
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_PRIME   = 2'd2;
  localparam logic [1:0] S_READOUT = 2'd3;

  logic [1:0]    state_q,     state_d;
  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;     // next RAM word to fetch
  logic [AW-1:0] cur_idx_q,   cur_idx_d;    // word currently draining
  logic [1:0]    byte_sel_q,  byte_sel_d;   // byte of cur_word on DataOut
  logic [31:0]   cur_word_q,  cur_word_d;
  logic [7:0]    data_out_q,  data_out_d;
  logic          data_ready_q, data_ready_d;

  logic          wr_en;
  logic          rd_en;
  logic [31:0]   rd_data;     // RAM read register = prefetched next word
  logic [7:0]    next_byte;

  sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (32),
    .AW    (AW)
  ) u_ram (
    .clk       (Clock),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (DataIn),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (rd_data)
  );

  // Byte that follows the one currently shown, within the same word.
  always_comb begin
    next_byte = cur_word_q[7:0];
    case (byte_sel_q)
      2'd0:    next_byte = cur_word_q[15:8];
      2'd1:    next_byte = cur_word_q[23:16];
      2'd2:    next_byte = cur_word_q[31:24];
      default: next_byte = cur_word_q[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cur_idx_d    = cur_idx_q;
    byte_sel_d   = byte_sel_q;
    cur_word_d   = cur_word_q;
    data_out_d   = data_out_q;
    data_ready_d = data_ready_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // wr_ptr_q is 0 here, so the trigger edge itself writes word 0.
        if (FastTrigger) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          rd_ptr_d = '0;
          state_d  = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);   // wraps back to 0 after last word
        if (wr_ptr_q == LAST_WORD) begin
          state_d = S_PRIME;
        end
      end

      S_PRIME: begin
        // Two cycles: fetch word 0, then fetch word 1 while word 0 moves
        // into the output register, leaving the prefetch slot full.
        rd_en    = 1'b1;
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (rd_ptr_q == AW'(1)) begin
          cur_word_d   = rd_data;
          data_out_d   = rd_data[7:0];
          data_ready_d = 1'b1;
          cur_idx_d    = '0;
          byte_sel_d   = 2'd0;
          state_d      = S_READOUT;
        end
      end

      S_READOUT: begin
        if (ReadEnable) begin
          if (byte_sel_q != 2'd3) begin
            byte_sel_d = byte_sel_q + 2'd1;
            data_out_d = next_byte;
          end else if (cur_idx_q == LAST_WORD) begin
            // Final byte consumed: DataOut keeps its last value.
            data_ready_d = 1'b0;
            rd_ptr_d     = '0;
            state_d      = S_IDLE;
          end else begin
            // Swap in the prefetched word and refill the prefetch slot.
            // Past the last word the fetch address wraps; that data is
            // never presented.
            cur_word_d = rd_data;
            data_out_d = rd_data[7:0];
            byte_sel_d = 2'd0;
            cur_idx_d  = cur_idx_q + AW'(1);
            rd_en      = 1'b1;
            rd_ptr_d   = rd_ptr_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cur_idx_q    <= '0;
      byte_sel_q   <= 2'd0;
      cur_word_q   <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cur_idx_q    <= cur_idx_d;
      byte_sel_q   <= byte_sel_d;
      cur_word_q   <= cur_word_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign DataOut   = data_out_q;
  assign DataReady = data_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_data_storage_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_storage_acc
// Purpose  : Directed self-checking bench for data_storage_acc (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_storage_acc;

  localparam int DEPTH  = 4;
  localparam int NBYTES = 4 * DEPTH;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] DataIn = '0;
  logic        FastTrigger = 1'b0;
  logic        ReadEnable = 1'b0;
  logic [7:0]  DataOut;
  logic        DataReady;

  int checks = 0;
  int passes = 0;

  logic [31:0] cap_words [DEPTH];

  data_storage_acc #(.DEPTH(DEPTH)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .DataIn      (DataIn),
    .FastTrigger (FastTrigger),
    .ReadEnable  (ReadEnable),
    .DataOut     (DataOut),
    .DataReady   (DataReady)
  );

  always #5 Clock = ~Clock;

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = cap_words[i / 4];
    return w[8 * (i % 4) +: 8];
  endfunction

  // Capture cap_words[]; extra_trig >= 0 re-asserts FastTrigger while that
  // word is being written. Ends with DataReady just risen.
  task automatic do_capture(input int extra_trig);
    for (int k = 0; k < DEPTH; k++) begin
      DataIn      = cap_words[k];
      FastTrigger = (k == 0) || (k == extra_trig);
      step();
      checks++;
      if (DataReady !== 1'b0)
        $display("FAIL capture_ready_low word=%0d got=%b exp=0", k, DataReady);
      else passes++;
    end
    FastTrigger = 1'b0;
    DataIn      = 32'hDEAD_BEEF;
    step();
    checks++;
    if (DataReady !== 1'b0)
      $display("FAIL prime_ready_early got=%b exp=0", DataReady);
    else passes++;
    step();
    checks++;
    if (DataReady !== 1'b1)
      $display("FAIL prime_ready_rise got=%b exp=1", DataReady);
    else passes++;
  endtask

  // Drain the full record with one strobe every 'gap' cycles. trig_byte >= 0
  // pulses FastTrigger together with the strobe that reveals that byte.
  task automatic run_readout(input int gap, input int trig_byte);
    checks++;
    if (DataOut !== exp_byte(0))
      $display("FAIL readout_byte0 got=%02h exp=%02h", DataOut, exp_byte(0));
    else passes++;
    for (int i = 1; i < NBYTES; i++) begin
      ReadEnable  = 1'b1;
      FastTrigger = (i == trig_byte);
      step();
      ReadEnable  = 1'b0;
      FastTrigger = 1'b0;
      checks++;
      if (DataOut !== exp_byte(i) || DataReady !== 1'b1)
        $display("FAIL readout_byte%0d got=%02h/%b exp=%02h/1",
                 i, DataOut, DataReady, exp_byte(i));
      else passes++;
      for (int g = 1; g < gap; g++) begin
        step();
        checks++;
        if (DataOut !== exp_byte(i) || DataReady !== 1'b1)
          $display("FAIL readout_hold%0d got=%02h/%b exp=%02h/1",
                   i, DataOut, DataReady, exp_byte(i));
        else passes++;
      end
    end
    ReadEnable = 1'b1;
    step();
    ReadEnable = 1'b0;
    checks++;
    if (DataReady !== 1'b0 || DataOut !== exp_byte(NBYTES - 1))
      $display("FAIL readout_end got=%02h/%b exp=%02h/0",
               DataOut, DataReady, exp_byte(NBYTES - 1));
    else passes++;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      FastTrigger = ~FastTrigger;
      step();
      checks++;
      if (DataReady !== 1'b0 || DataOut !== 8'h00)
        $display("FAIL reset_hold%0d got=%02h/%b exp=00/0", c, DataOut, DataReady);
      else passes++;
    end
    FastTrigger = 1'b0;
    Reset       = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (DataReady !== 1'b0 || DataOut !== 8'h00)
        $display("FAIL reset_release%0d got=%02h/%b exp=00/0", c, DataOut, DataReady);
      else passes++;
    end
  endtask

  task automatic test_basic();
    for (int n = 0; n < DEPTH; n++) cap_words[n] = {4{8'(n)}};
    do_capture(-1);
    run_readout(1, -1);
  endtask

  task automatic test_byte_order();
    cap_words[0] = 32'h4433_2211;
    cap_words[1] = 32'h8877_6655;
    cap_words[2] = 32'hCCBB_AA99;
    cap_words[3] = 32'h00FF_EEDD;
    step();
    do_capture(-1);
    run_readout(1, -1);
  endtask

  task automatic test_sparse();
    for (int n = 0; n < DEPTH; n++) cap_words[n] = {4{8'(n)}};
    step();
    do_capture(-1);
    run_readout(7, -1);
  endtask

  task automatic test_trigger_ignored();
    cap_words[0] = 32'h0302_0100;
    cap_words[1] = 32'h1312_1110;
    cap_words[2] = 32'h2322_2120;
    cap_words[3] = 32'h3332_3130;
    step();
    do_capture(2);
    run_readout(1, 5);
    // Strobes with nothing ready, and no queued trigger may start a capture.
    ReadEnable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (DataReady !== 1'b0 || DataOut !== 8'h33)
        $display("FAIL idle_after_readout%0d got=%02h/%b exp=33/0", c, DataOut, DataReady);
      else passes++;
    end
    ReadEnable = 1'b0;
    cap_words[0] = 32'hA3A2_A1A0;
    cap_words[1] = 32'hB3B2_B1B0;
    cap_words[2] = 32'hC3C2_C1C0;
    cap_words[3] = 32'hD3D2_D1D0;
    do_capture(-1);
    run_readout(1, -1);
  endtask

  task automatic test_reset_mid_readout();
    cap_words[0] = 32'h5A5A_5A5A;
    cap_words[1] = 32'h6B6B_6B6B;
    cap_words[2] = 32'h7C7C_7C7C;
    cap_words[3] = 32'h8D8D_8D8D;
    step();
    do_capture(-1);
    for (int i = 1; i <= 6; i++) begin
      ReadEnable = 1'b1;
      step();
      checks++;
      if (DataOut !== exp_byte(i))
        $display("FAIL pre_reset_byte%0d got=%02h exp=%02h", i, DataOut, exp_byte(i));
      else passes++;
    end
    ReadEnable = 1'b0;
    Reset      = 1'b0;
    #1;
    checks++;
    if (DataReady !== 1'b0 || DataOut !== 8'h00)
      $display("FAIL async_reset got=%02h/%b exp=00/0", DataOut, DataReady);
    else passes++;
    step();
    step();
    Reset = 1'b1;
    step();
    checks++;
    if (DataReady !== 1'b0)
      $display("FAIL post_reset_ready got=%b exp=0", DataReady);
    else passes++;
    cap_words[0] = 32'h0F0E_0D0C;
    cap_words[1] = 32'h1F1E_1D1C;
    cap_words[2] = 32'h2F2E_2D2C;
    cap_words[3] = 32'h3F3E_3D3C;
    do_capture(-1);
    run_readout(1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_order();
    test_sparse();
    test_trigger_ignored();
    test_reset_mid_readout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_storage_acc.md
Name: data_storage_acc

Overview:
- Single-clock capture buffer for the fast ADC path.
- On a FastTrigger pulse it records DEPTH consecutive 32-bit ADC words (four 8-bit samples each) into internal RAM.
- It then presents the record one byte at a time to the UART transmit wrapper using a ready/strobe handshake.
- It sits between the ADC deserializer and the TxD wrapper: DataReady drives the wrapper's valid/streaming inputs, and the wrapper's strobe drives ReadEnable.

Parameters:
- DEPTH, 256, number of 32-bit words captured per trigger; power of two, ≥ 2.
- AW, log2(DEPTH), word address width; derived, not overridden.

Ports:
- Clock  in  1  single system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted when 0).
- DataIn  in  32  four ADC samples; [7:0] is the oldest sample, [31:24] the newest.
- FastTrigger  in  1  capture start request, sampled on rising edge.
- ReadEnable  in  1  one-cycle strobe consuming the byte currently on DataOut.
- DataOut  out  8  current readout byte; valid while DataReady=1.
- DataReady  out  1  high while unread bytes remain.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; DataOut=0; DataReady=0; all pointers=0.
  - RAM contents are don't-care.
  - Reset mid-capture or mid-readout aborts the operation; no partial data is ever presented.
- FSM states: IDLE, CAPTURE, PRIME, READOUT.
- IDLE:
  - FastTrigger=1 at an edge → DataIn is written to word 0 on that same edge; next state is CAPTURE with wr_ptr=1.
  - DEPTH=1 is not supported.
- CAPTURE:
  - Write DataIn to word wr_ptr every cycle.
  - After word DEPTH-1 is written → PRIME.
  - FastTrigger is ignored.
- PRIME:
  - Synchronous RAM read of word 0, then load it into the output word register.
  - DataReady rises exactly 2 cycles after the edge that wrote word DEPTH-1.
  - DataOut = word0[7:0] at that point.
- READOUT:
  - Byte order per word: [7:0], [15:8], [23:16], [31:24]; words in ascending address.
  - Each edge with ReadEnable=1 advances to the next byte; DataOut shows it on that same edge.
  - ReadEnable may be held high every cycle; no bubbles allowed. The next word is prefetched into a second register while the current word drains.
  - After the edge consuming byte 4*DEPTH-1: DataReady=0, DataOut holds its last value, state=IDLE.
  - A new trigger is accepted from the following edge onward.
- ReadEnable with DataReady=0 has no effect.
- FastTrigger has no effect outside IDLE, including during CAPTURE, PRIME and READOUT. It is not queued.
- DataReady is registered (no combinational path from inputs to outputs).
- Capture always sees the full record of DEPTH words; there is no overflow or underflow condition.

Decomposition:
- No shared package needed. The state encoding is a localparam inside the module.
- One natural sub-module: sdp_ram (simple dual-port, 32 bits x DEPTH, one write port, one registered read port, single clock).
- FSM, pointers and byte mux live in data_storage_acc.

Test Plan:
- Reset: hold Reset=0 for 3 cycles with FastTrigger toggling → DataReady=0 and DataOut=0 throughout; no capture starts after release.
- Basic capture (DEPTH=4): ramp DataIn={4{n}}, n=0 on the trigger cycle.
  - DataReady rises 2 cycles after the 4th word.
  - Bytes read with ReadEnable every cycle are 0,0,0,0,1,1,1,1,2,…,3 (16 bytes).
  - DataReady falls after the 16th strobe.
- Byte order: DataIn=32'h44332211 captured as word 0 → first four bytes are 11,22,33,44.
- Sparse strobes: ReadEnable pulsed once every 7 cycles → identical 16-byte sequence; DataOut stable between strobes; no byte skipped or repeated.
- Trigger during capture/readout: extra FastTrigger pulses at capture word 2 and readout byte 5 → record unchanged; exactly 16 bytes delivered; new trigger after DataReady falls starts a fresh capture.
- Reset mid-readout after byte 6 → DataReady=0 immediately (asynchronous); next trigger yields a complete fresh record starting at word 0.
